nrf_spi_byte_master: RTL

Byte-level SPI master driving the nRF24L01 pins (spi_sck, spi_mosi, spi_csn, sampling spi_miso). It sits directly downstream of the nRF command sequencer: the sequencer hands it one byte at a time, and it returns the byte shifted in from MISO. It is SPI mode 0 (CPOL=0, CPHA=0), MSB first. CSN is held low across chained bytes so a command byte and its payload form one transaction.

---
 rtl/nrf_spi_byte_master.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/nrf_spi_byte_master.sv
// ---------------------------------------------------------------------------
// nrf_spi_byte_master
//
// Byte-level SPI master for the nRF24L01 (mode 0: SCK idles low, MOSI is
// launched on falling edges and MISO is captured on rising edges, MSB first).
// The command sequencer hands over one byte at a time. CSN stays low across
// chained bytes (last=0) so that a command byte and its payload form one
// transaction. A byte with last=1 is followed by a CSN hold time, the CSN
// release and a CSN-high gap.
//
// Ports
//   clk       system clock
//   reset     synchronous, active-high reset
//   start     transfer request, accepted only while ready=1
//   tx_byte   byte to send, sampled on the accepted start cycle
//   last      sampled with start; 1 = release CSN after this byte
//   ready     start will be accepted this cycle
//   busy      a byte is shifting or CSN is being released
//   rx_byte   last byte received, held until the next rx_valid
//   rx_valid  one-cycle pulse when rx_byte updates
//   spi_miso  nRF MISO
//   spi_sck   SCK, idles low
//   spi_mosi  MOSI
//   spi_csn   chip select, active low
//
// Parameter
//   CLK_DIV   clk cycles per SCK half-period (>= 2)
// ---------------------------------------------------------------------------
module nrf_spi_byte_master #(
   parameter int CLK_DIV = 25
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] tx_byte,
   input  logic       last,
   output logic       ready,
   output logic       busy,
   output logic [7:0] rx_byte,
   output logic       rx_valid,
   input  logic       spi_miso,
   output logic       spi_sck,
   output logic       spi_mosi,
   output logic       spi_csn
);

   localparam int            CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT,
      HOLD,
      GAP,
      CHAIN
   } state_t;

   state_t        state_reg;
   logic [CW-1:0] div_cnt_reg;   // cycles within the current half-period
   logic [3:0]    half_cnt_reg;  // SCK edges already produced in this byte
   logic [7:0]    shift_reg;     // TX bits leave at bit 7, RX bits enter at bit 0
   logic          last_reg;
   logic          div_done;

   assign div_done = (div_cnt_reg == DIV_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= IDLE;
         div_cnt_reg  <= '0;
         half_cnt_reg <= '0;
         shift_reg    <= '0;
         last_reg     <= 1'b0;
         ready        <= 1'b1;
         busy         <= 1'b0;
         rx_byte      <= '0;
         rx_valid     <= 1'b0;
         spi_sck      <= 1'b0;
         spi_mosi     <= 1'b0;
         spi_csn      <= 1'b1;
      end else begin
         rx_valid    <= 1'b0;
         div_cnt_reg <= div_done ? '0 : div_cnt_reg + 1'b1;

         case (state_reg)
            IDLE: begin
               div_cnt_reg <= '0;
               spi_mosi    <= 1'b0;
               if (start) begin
                  shift_reg <= tx_byte;
                  last_reg  <= last;
                  spi_csn   <= 1'b0;
                  spi_mosi  <= tx_byte[7];
                  ready     <= 1'b0;
                  busy      <= 1'b1;
                  state_reg <= SETUP;
               end
            end

            // CSN setup time. Its last cycle also produces the first rising
            // edge, so SHIFT is entered with one edge already done.
            SETUP: begin
               if (div_done) begin
                  spi_sck      <= 1'b1;
                  shift_reg    <= {shift_reg[6:0], spi_miso};
                  half_cnt_reg <= 4'd1;
                  state_reg    <= SHIFT;
               end
            end

            // Even edge index = rising edge (capture), odd = falling edge
            // (launch next bit). Edge 15 is the 8th falling edge: the byte
            // is complete and no further bit is launched.
            SHIFT: begin
               if (div_done) begin
                  spi_sck      <= ~spi_sck;
                  half_cnt_reg <= half_cnt_reg + 1'b1;
                  if (!half_cnt_reg[0]) begin
                     shift_reg <= {shift_reg[6:0], spi_miso};
                  end else if (half_cnt_reg != 4'd15) begin
                     spi_mosi <= shift_reg[7];
                  end else begin
                     rx_byte   <= shift_reg;
                     rx_valid  <= 1'b1;
                     state_reg <= last_reg ? HOLD : CHAIN;
                  end
               end
            end

            HOLD: begin
               if (div_done) begin
                  spi_csn   <= 1'b1;
                  state_reg <= GAP;
               end
            end

            GAP: begin
               if (div_done) begin
                  busy      <= 1'b0;
                  ready     <= 1'b1;
                  state_reg <= IDLE;
               end
            end

            // First CHAIN cycle still reports busy (it is the rx_valid
            // cycle); ready rises one cycle later. The divider is preloaded
            // with 1 so the first rising edge of the next byte lands
            // CLK_DIV cycles after acceptance.
            CHAIN: begin
               div_cnt_reg <= CW'(1);
               if (!ready) begin
                  ready <= 1'b1;
                  busy  <= 1'b0;
               end else if (start) begin
                  shift_reg    <= tx_byte;
                  last_reg     <= last;
                  spi_mosi     <= tx_byte[7];
                  half_cnt_reg <= '0;
                  ready        <= 1'b0;
                  busy         <= 1'b1;
                  state_reg    <= SHIFT;
               end
            end

            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule
